// File: rtl/mips_pipe_control_if.sv
// Control-unit bus: ID-stage instruction fields in, stage controls out.
// master = datapath side (drives id_*/ex_zero), slave = mips_pipe_control.
interface mips_pipe_control_if #(
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 3
);
  logic               id_valid;
  logic [5:0]         id_opcode;
  logic [5:0]         id_funct;
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic [REG_AW-1:0]  id_rd;
  logic               ex_zero;

  logic               pc_en;
  logic               ifid_en;
  logic               ifid_flush;
  logic [1:0]         pc_sel;
  logic               id_sign_xtend;

  logic               ex_valid;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic               ex_alu_src;
  logic               ex_illegal;
  logic [REG_AW-1:0]  ex_dst_reg;

  logic               mem_valid;
  logic               mem_read;
  logic               mem_write;

  logic               wb_valid;
  logic               wb_reg_write;
  logic               wb_mem2reg;
  logic               wb_link;
  logic [REG_AW-1:0]  wb_dst_reg;

  modport master (
    output id_valid, id_opcode, id_funct,
    output id_rs, id_rt, id_rd, ex_zero,
    input  pc_en, ifid_en, ifid_flush,
    input  pc_sel, id_sign_xtend,
    input  ex_valid, ex_alu_op, ex_alu_src,
    input  ex_illegal, ex_dst_reg,
    input  mem_valid, mem_read, mem_write,
    input  wb_valid, wb_reg_write, wb_mem2reg,
    input  wb_link, wb_dst_reg
  );

  modport slave (
    input  id_valid, id_opcode, id_funct,
    input  id_rs, id_rt, id_rd, ex_zero,
    output pc_en, ifid_en, ifid_flush,
    output pc_sel, id_sign_xtend,
    output ex_valid, ex_alu_op, ex_alu_src,
    output ex_illegal, ex_dst_reg,
    output mem_valid, mem_read, mem_write,
    output wb_valid, wb_reg_write, wb_mem2reg,
    output wb_link, wb_dst_reg
  );
endinterface

// File: rtl/mips_pipe_control.sv
// Pipelined MIPS control: ID decode, ID/EX-EX/MEM-MEM/WB control regs,
// load-use interlock, ID jumps, EX branches. Ports: clk, rst, bus(slave).
module mips_pipe_control #(
  parameter int REG_AW         = 5,
  parameter int ALUOP_W        = 3,
  parameter int LINK_REG       = 31,
  parameter int LOAD_USE_STALL = 1
) (
  input logic clk,
  input logic rst,
  mips_pipe_control_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef struct packed {
    logic               valid;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               illegal;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem2reg;
    logic               link;
    logic               branch;
    logic               bne;
    logic [REG_AW-1:0]  dst;
  } ex_t;

  typedef struct packed {
    logic              valid;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem2reg;
    logic              link;
    logic [REG_AW-1:0] dst;
  } mem_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem2reg;
    logic              link;
    logic [REG_AW-1:0] dst;
  } wb_t;

  ex_t  r_ex;
  mem_t r_mem;
  wb_t  r_wb;

  ex_t  w_dec;
  logic w_jump;
  logic w_jr;
  logic w_sx;
  logic w_uses_rt;
  logic w_hazard;
  logic w_taken;
  logic w_stall;
  logic w_jump_id;
  logic w_bubble;

  always_comb begin
    w_dec  = '0;
    w_jump = 1'b0;
    w_jr   = 1'b0;
    w_sx   = 1'b0;
    if (bus.id_valid) begin
      w_dec.valid = 1'b1;
      case (bus.id_opcode)
        OP_RTYPE: begin
          w_dec.alu_op = ALUOP_W'(7);
          w_dec.dst    = bus.id_rd;
          w_sx         = ~bus.id_funct[0];
          if (bus.id_funct == FN_JR) begin
            w_jr = 1'b1;
          end else begin
            w_dec.reg_write = 1'b1;
          end
        end
        OP_ADDI, OP_LW: begin
          w_dec.alu_src   = 1'b1;
          w_dec.reg_write = 1'b1;
          w_dec.dst       = bus.id_rt;
          w_dec.alu_op    = ALUOP_W'(2);
          w_sx            = 1'b1;
          if (bus.id_opcode == OP_LW) begin
            w_dec.mem_read = 1'b1;
            w_dec.mem2reg  = 1'b1;
          end
        end
        OP_SW: begin
          w_dec.alu_src   = 1'b1;
          w_dec.mem_write = 1'b1;
          w_dec.alu_op    = ALUOP_W'(2);
          w_sx            = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          w_dec.branch = 1'b1;
          w_dec.bne    = bus.id_opcode[0];
          w_dec.alu_op = ALUOP_W'(6);
          w_sx         = 1'b1;
        end
        OP_J: begin
          w_jump = 1'b1;
        end
        OP_JAL: begin
          w_jump          = 1'b1;
          w_dec.reg_write = 1'b1;
          w_dec.link      = 1'b1;
          w_dec.dst       = REG_AW'(LINK_REG);
        end
        default: begin
          w_dec.illegal = 1'b1;
        end
      endcase
    end
  end

  // rt is a true source only for these formats
  assign w_uses_rt = (bus.id_opcode == OP_RTYPE) ||
                     (bus.id_opcode == OP_BEQ)   ||
                     (bus.id_opcode == OP_BNE)   ||
                     (bus.id_opcode == OP_SW);

  assign w_hazard = bus.id_valid && r_ex.valid &&
                    r_ex.mem_read && (r_ex.dst != '0) &&
                    ((r_ex.dst == bus.id_rs) ||
                     (w_uses_rt && (r_ex.dst == bus.id_rt)));

  assign w_taken = r_ex.valid && r_ex.branch &&
                   (r_ex.bne ? ~bus.ex_zero : bus.ex_zero);

  // a taken branch squashes whatever sits in ID
  assign w_stall   = (LOAD_USE_STALL != 0) && w_hazard && !w_taken;
  assign w_jump_id = (w_jump || w_jr) && !w_stall && !w_taken;
  assign w_bubble  = w_taken || w_stall;

  always_comb begin
    bus.pc_en      = 1'b1;
    bus.ifid_en    = 1'b1;
    bus.ifid_flush = 1'b0;
    bus.pc_sel     = 2'b00;
    if (!rst) begin
      unique case (1'b1)
        w_taken: begin
          bus.pc_sel     = 2'b01;
          bus.ifid_flush = 1'b1;
        end
        w_stall: begin
          bus.pc_en   = 1'b0;
          bus.ifid_en = 1'b0;
        end
        w_jump_id: begin
          bus.pc_sel     = w_jr ? 2'b11 : 2'b10;
          bus.ifid_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_ex            <= w_bubble ? '0 : w_dec;
      r_mem.valid     <= r_ex.valid;
      r_mem.mem_read  <= r_ex.mem_read;
      r_mem.mem_write <= r_ex.mem_write;
      r_mem.reg_write <= r_ex.reg_write;
      r_mem.mem2reg   <= r_ex.mem2reg;
      r_mem.link      <= r_ex.link;
      r_mem.dst       <= r_ex.dst;
      r_wb.valid      <= r_mem.valid;
      r_wb.reg_write  <= r_mem.reg_write;
      r_wb.mem2reg    <= r_mem.mem2reg;
      r_wb.link       <= r_mem.link;
      r_wb.dst        <= r_mem.dst;
    end
  end

  assign bus.id_sign_xtend = w_sx;
  assign bus.ex_valid      = r_ex.valid;
  assign bus.ex_alu_op     = r_ex.alu_op;
  assign bus.ex_alu_src    = r_ex.alu_src;
  assign bus.ex_illegal    = r_ex.illegal;
  assign bus.ex_dst_reg    = r_ex.dst;
  assign bus.mem_valid     = r_mem.valid;
  assign bus.mem_read      = r_mem.mem_read;
  assign bus.mem_write     = r_mem.mem_write;
  assign bus.wb_valid      = r_wb.valid;
  assign bus.wb_reg_write  = r_wb.reg_write;
  assign bus.wb_mem2reg    = r_wb.mem2reg;
  assign bus.wb_link       = r_wb.link;
  assign bus.wb_dst_reg    = r_wb.dst;

endmodule

// File: doc/mips_pipe_control.md
Name: mips_pipe_control

Overview:
- Pipelined successor to the single-cycle MIPS control decoder.
- Decodes opcode/funct in ID, then carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards (stall) and resolves jumps in ID and branches in EX (redirect + flush).
- Sits between the instruction register and the 5-stage datapath; all stage enables and PC select come from here.

Parameters:
REG_AW, 5, register-address width.
ALUOP_W, 3, ALU operation code width.
LINK_REG, 31, destination register written by JAL.
LOAD_USE_STALL, 1, 1 = hardware load-use interlock; 0 = no interlock (software-scheduled).

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
id_valid  in  1  instruction in ID is real (not a bubble).
id_opcode  in  6  instruction[31:26].
id_funct  in  6  instruction[5:0].
id_rs  in  REG_AW  source register rs.
id_rt  in  REG_AW  source register rt.
id_rd  in  REG_AW  destination register rd.
ex_zero  in  1  ALU zero flag of the instruction currently in EX.
pc_en  out  1  PC update enable (combinational).
ifid_en  out  1  IF/ID register enable (combinational).
ifid_flush  out  1  IF/ID register loads a bubble (combinational).
pc_sel  out  2  00 = PC+4, 01 = branch target, 10 = J/JAL target, 11 = JR rs value (combinational).
id_sign_xtend  out  1  immediate extension mode for the ID-stage instruction (combinational).
ex_valid, ex_alu_op[ALUOP_W], ex_alu_src, ex_illegal  out  registered EX controls.
ex_dst_reg  out  REG_AW  registered EX destination register.
mem_valid, mem_read, mem_write  out  registered MEM controls.
wb_valid, wb_reg_write, wb_mem2reg, wb_link  out  registered WB controls.
wb_dst_reg  out  REG_AW  registered WB destination register.

Behaviour:
- Decode (combinational, every output defaulted to 0 before the case):
  - R-type 000000: reg_write=1, dst=rd, alu_op=111, sign_xtend=~funct[0].
  - JR (R-type with funct 001000): reg_write=0, jump-reg.
  - ADDI 001000: alu_src=1, reg_write=1, dst=rt, alu_op=010, sign_xtend=1.
  - LW 100011: as ADDI, plus mem_read=1 and mem2reg=1.
  - SW 101011: alu_src=1, mem_write=1, alu_op=010, sign_xtend=1.
  - BEQ 000100 / BNE 000101: branch=1, alu_op=110, sign_xtend=1; branch polarity is carried into EX.
  - J 000010: jump.
  - JAL 000011: jump, reg_write=1, link=1, dst=LINK_REG.
  - Any other opcode: all controls 0, illegal=1.
  - id_valid=0 forces all controls and illegal to 0.
- Pipeline:
  - Each stage register holds a valid bit plus its controls.
  - Each stage advances every cycle; the ID/EX load is replaced by a bubble on a stall or flush.
  - ex_illegal is a one-cycle-per-instruction flag travelling with the instruction.
- Load-use stall (LOAD_USE_STALL=1):
  - Condition: ex_valid & ex_mem_read & ex_dst_reg!=0 & (ex_dst_reg==id_rs, or ex_dst_reg==id_rt for R-type/BEQ/BNE/SW).
  - Response: pc_en=0, ifid_en=0, ID/EX loads a bubble.
  - Exactly one stall cycle per hazard.
- Jump (ID stage, valid, not stalled):
  - pc_sel=10 (J/JAL) or 11 (JR).
  - ifid_flush=1 for one cycle.
  - The jump instruction itself proceeds down the pipe (JAL writes the link register).
- Branch (EX stage):
  - Taken = ex_valid & branch & (beq ? ex_zero : ~ex_zero).
  - When taken: pc_sel=01, ifid_flush=1, ID/EX loads a bubble, pc_en=1.
- Priority (highest first): EX taken branch > load-use stall > ID jump > sequential.
  - A taken branch cancels a coincident stall or jump in ID.
- Write to $0 is permitted by control; the register file ignores it.
- Reset:
  - All valid bits and registered controls are 0; dst registers are 0.
  - Combinational outputs: pc_en=1, ifid_en=1, ifid_flush=0, pc_sel=00.
  - Reset asserted mid-stall or mid-flush clears everything on the next clock edge.
- Latency: control for an instruction appears on ex_* 1 cycle after decode, mem_* 2 cycles after, wb_* 3 cycles after.

Test Plan:
- ADDI $t0 (opcode 001000, rt=8) -> ex_alu_src=1, ex_alu_op=010 next cycle; wb_reg_write=1, wb_dst_reg=8 three cycles later.
- LW $8 followed by an R-type with rs=8 -> one cycle of pc_en=0 and ifid_en=0, ex_valid=0 bubble; the R-type then reaches EX. With LOAD_USE_STALL=0: no stall.
- BNE in EX with ex_zero=0 -> pc_sel=01, ifid_flush=1, next ex_valid=0. Same case with ex_zero=1 -> no redirect.
- JAL in ID -> pc_sel=10, ifid_flush=1; three cycles later wb_link=1, wb_dst_reg=31, wb_reg_write=1. JR -> pc_sel=11, wb_reg_write=0.
- Taken BEQ in EX while a JR sits in ID -> pc_sel=01 and the JR is flushed. rst pulsed mid-stall -> all valids 0 and pc_en=1 next cycle.
- Opcode 111111 -> ex_illegal=1 for one cycle; mem_write=0 and wb_reg_write=0 for that instruction.
